// File: rtl/pwm_cap_pkg.sv
// Shared types and default constants for the PWM capture block.
package pwm_cap_pkg;

    localparam int DEF_CNT_W   = 8;
    localparam int DEF_PERIOD  = 16;
    localparam int DEF_TIMEOUT = 40;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_STUCK   = 2'd2
    } state_t;

endpackage

// File: rtl/sync_edge.sv
// Three-flop synchronizer for an asynchronous line, with single-cycle edge strobes.
module sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1;
    logic s2;
    logic s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // s3 only exists to compare against s2 for edge detection
    assign level = s2;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;

endmodule

// File: rtl/pwm_capture.sv
// Measures high time and period of a synchronized PWM line, recovers the duty code
// and flags lines that stop toggling or have the wrong period.
module pwm_capture
    import pwm_cap_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int PERIOD  = DEF_PERIOD,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pwm_in,
    output logic [CNT_W-1:0] high_cnt,
    output logic [CNT_W-1:0] period_cnt,
    output logic [3:0]       duty_code,
    output logic             valid,
    output logic             locked,
    output logic             period_err,
    output logic             stuck_hi,
    output logic             stuck_lo
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + CNT_ONE : v;
    endfunction

    logic level;
    logic rise;
    logic fall;

    sync_edge u_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (pwm_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    state_t           state;
    logic [CNT_W-1:0] pcnt;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W-1:0] run;
    logic             good_period;

    assign good_period = (pcnt == PERIOD_C) && (hcnt != '0) && (hcnt <= PERIOD_C - CNT_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            pcnt       <= '0;
            hcnt       <= '0;
            run        <= '0;
            high_cnt   <= '0;
            period_cnt <= '0;
            duty_code  <= 4'd0;
            valid      <= 1'b0;
            locked     <= 1'b0;
            period_err <= 1'b0;
            stuck_hi   <= 1'b0;
            stuck_lo   <= 1'b0;
        end else begin
            valid <= 1'b0;
            run   <= (rise || fall) ? '0 : sat_inc(run, 1'b1);

            if (rise) begin
                // A rise closes the running period only if one was being measured
                if (state == ST_MEASURE) begin
                    period_cnt <= pcnt;
                    high_cnt   <= hcnt;
                    valid      <= 1'b1;
                    stuck_hi   <= 1'b0;
                    stuck_lo   <= 1'b0;
                    if (good_period) begin
                        duty_code  <= 4'(hcnt - CNT_ONE);
                        locked     <= 1'b1;
                        period_err <= 1'b0;
                    end else begin
                        locked     <= 1'b0;
                        period_err <= 1'b1;
                    end
                end
                pcnt  <= CNT_ONE;
                hcnt  <= CNT_ONE;
                state <= ST_MEASURE;
            end else begin
                if (state == ST_MEASURE) begin
                    pcnt <= sat_inc(pcnt, 1'b1);
                    hcnt <= sat_inc(hcnt, level);
                end
                if ((state != ST_STUCK) && !fall && (run == TO_LAST)) begin
                    state  <= ST_STUCK;
                    locked <= 1'b0;
                    if (level) begin
                        stuck_hi  <= 1'b1;
                        duty_code <= 4'd15;
                        valid     <= 1'b1;
                    end else begin
                        stuck_lo  <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture: edge-timestamp reference model plus literal checks.
module tb_pwm_capture;

    localparam int CNT_W   = 8;
    localparam int PERIOD  = 16;
    localparam int TIMEOUT = 40;
    localparam int SAT     = (1 << CNT_W) - 1;
    localparam int HN      = 16384;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             pwm_in = 1'b0;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] period_cnt;
    logic [3:0]       duty_code;
    logic             valid;
    logic             locked;
    logic             period_err;
    logic             stuck_hi;
    logic             stuck_lo;

    pwm_capture #(.CNT_W(CNT_W), .PERIOD(PERIOD), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .duty_code  (duty_code),
        .valid      (valid),
        .locked     (locked),
        .period_err (period_err),
        .stuck_hi   (stuck_hi),
        .stuck_lo   (stuck_lo)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int bad   = 0;
    int phase = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: synchronizer delay, then periods from rise timestamps,
    // high time from the recorded level history, stuck from time since last edge.
    int               tk = 0;
    int               rise_t = 0;
    int               edge_t = 0;
    int               mode = 0;
    bit               m_s1, m_s2, m_s3;
    bit               s2hist [HN];
    logic [CNT_W-1:0] e_high = '0;
    logic [CNT_W-1:0] e_per = '0;
    logic [3:0]       e_code = '0;
    bit               e_valid, e_locked, e_perr, e_shi, e_slo;

    task automatic model_step();
        bit r, f;
        int per, hi;
        r = m_s2 & ~m_s3;
        f = ~m_s2 & m_s3;
        e_valid = 1'b0;
        if (rst) begin
            e_high = '0; e_per = '0; e_code = '0;
            e_locked = 0; e_perr = 0; e_shi = 0; e_slo = 0;
            mode = 0; edge_t = tk;
            m_s1 = 0; m_s2 = 0; m_s3 = 0;
        end else begin
            s2hist[tk % HN] = m_s2;
            if (r) begin
                if (mode == 1) begin
                    per = tk - rise_t;
                    if (per > SAT) per = SAT;
                    hi = 0;
                    for (int k = rise_t; k < tk && hi < SAT; k++) hi += int'(s2hist[k % HN]);
                    e_per = CNT_W'(per);
                    e_high = CNT_W'(hi);
                    e_valid = 1; e_shi = 0; e_slo = 0;
                    if (per == PERIOD && hi >= 1 && hi <= PERIOD - 1) begin
                        e_code = 4'(hi - 1); e_locked = 1; e_perr = 0;
                    end else begin
                        e_locked = 0; e_perr = 1;
                    end
                end
                mode = 1;
                rise_t = tk;
            end else if (mode != 2 && !f && (tk - edge_t) == TIMEOUT) begin
                mode = 2;
                e_locked = 0;
                if (m_s2) begin
                    e_shi = 1; e_code = 4'd15; e_valid = 1;
                end else begin
                    e_slo = 1;
                end
            end
            if (r || f) edge_t = tk;
            m_s3 = m_s2; m_s2 = m_s1; m_s1 = pwm_in;
        end
        tk++;
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("high_cnt", high_cnt, e_high);
            check("period_cnt", period_cnt, e_per);
            check("duty_code", duty_code, e_code);
            check("valid", valid, e_valid);
            check("locked", locked, e_locked);
            check("period_err", period_err, e_perr);
            check("stuck_hi", stuck_hi, e_shi);
            check("stuck_lo", stuck_lo, e_slo);
            if (phase == 3 && valid === 1'b1 && locked === 1'b1 && duty_code != 4'd3 && duty_code != 4'd10)
                bad++;
        end
    end

    // Stimulus generator: 0 = 16-step PWM, 1 = constant high, 2 = constant low, 3 = 12-cycle square
    int gmode = 2;
    int gduty = 0;
    int gcnt  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
        case (gmode)
            0: begin gcnt = (gcnt + 1) % 16; pwm_in = (gcnt <= gduty); end
            1: pwm_in = 1'b1;
            2: pwm_in = 1'b0;
            default: begin gcnt = (gcnt + 1) % 12; pwm_in = (gcnt < 4); end
        endcase
    endtask

    task automatic run_until(input int sel, input int limit, output int n, output int nv);
        bit hit;
        n = 0; nv = 0; hit = 0;
        while (!hit && n < limit) begin
            tick();
            n++;
            if (valid === 1'b1) nv++;
            case (sel)
                0: hit = (valid === 1'b1);
                1: hit = (stuck_hi === 1'b1);
                default: hit = (stuck_lo === 1'b1);
            endcase
        end
    endtask

    task automatic run_n(input int cnt, output int nv, output int nperr);
        nv = 0; nperr = 0;
        for (int i = 0; i < cnt; i++) begin
            tick();
            if (valid === 1'b1) nv++;
            if (valid === 1'b1 && period_err === 1'b1) nperr++;
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_high_cnt"}, high_cnt, 0);
        check({tag, "_period_cnt"}, period_cnt, 0);
        check({tag, "_duty_code"}, duty_code, 0);
        check({tag, "_valid"}, valid, 0);
        check({tag, "_locked"}, locked, 0);
        check({tag, "_period_err"}, period_err, 0);
        check({tag, "_stuck_hi"}, stuck_hi, 0);
        check({tag, "_stuck_lo"}, stuck_lo, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        int n, nv, np;
        repeat (3) tick();
        chk_en = 1'b1;
        check_all_zero("reset");
        rst = 1'b0;

        // Duty 5 from a clean start
        phase = 1; gmode = 0; gduty = 5; gcnt = 15;
        tick();
        run_until(0, 40, n, nv);
        check("d5_first_valid_latency", n, 19);
        check("d5_high", high_cnt, 6);
        check("d5_period", period_cnt, 16);
        check("d5_code", duty_code, 5);
        check("d5_locked", locked, 1);
        for (int i = 0; i < 2; i++) begin
            run_until(0, 40, n, nv);
            check("d5_valid_interval", n, 16);
        end

        // Duty 3, then switch to 10 mid-period
        phase = 2; gduty = 3;
        run_n(48, nv, np);
        check("d3_code", duty_code, 3);
        check("d3_high", high_cnt, 4);
        check("d3_locked", locked, 1);
        phase = 3;
        while (gcnt != 6) tick();
        gduty = 10;
        run_n(64, nv, np);
        check("d10_err_periods", np, 2);
        check("d10_code", duty_code, 10);
        check("d10_high", high_cnt, 11);
        check("d10_period", period_cnt, 16);
        check("d10_locked", locked, 1);
        check("d10_no_intermediate", bad, 0);
        phase = 4;

        // Constant high from reset
        rst = 1'b1; gmode = 2;
        repeat (2) tick();
        rst = 1'b0; gmode = 1;
        tick();
        run_until(1, 60, n, nv);
        check("hi_stuck_latency", n, 43);
        run_n(20, n, np);
        check("hi_valid_count", nv + n, 1);
        check("hi_stuck_hi", stuck_hi, 1);
        check("hi_code", duty_code, 15);
        check("hi_locked", locked, 0);
        check("hi_stuck_lo", stuck_lo, 0);

        // Lock on duty 5, then hold low
        rst = 1'b1; gmode = 2;
        tick();
        rst = 1'b0; gmode = 0; gduty = 5; gcnt = 15;
        run_until(0, 40, n, nv);
        run_until(0, 40, n, nv);
        check("lo_pre_locked", locked, 1);
        gmode = 2;
        tick();
        run_until(2, 60, n, nv);
        check("lo_stuck_latency", n, 43);
        check("lo_no_valid", nv, 0);
        check("lo_code", duty_code, 5);
        check("lo_locked", locked, 0);
        check("lo_high_held", high_cnt, 6);
        check("lo_period_held", period_cnt, 16);

        // Square wave period 12, high 4
        gmode = 3; gcnt = 11;
        tick();
        run_until(0, 40, n, nv);
        check("sq_latency", n, 15);
        check("sq_period", period_cnt, 12);
        check("sq_high", high_cnt, 4);
        check("sq_period_err", period_err, 1);
        check("sq_locked", locked, 0);
        check("sq_code", duty_code, 5);
        check("sq_stuck_lo", stuck_lo, 0);

        // Reset pulse mid-period while the line is low
        gmode = 0; gduty = 5; gcnt = 15;
        run_n(40, nv, np);
        while (gcnt != 8) tick();
        rst = 1'b1;
        tick();
        check_all_zero("midrst");
        rst = 1'b0;
        run_until(0, 60, n, nv);
        check("midrst_first_valid", n, 26);
        check("midrst_high", high_cnt, 6);
        check("midrst_period", period_cnt, 16);
        check("midrst_code", duty_code, 5);
        check("midrst_locked", locked, 1);
        repeat (4) tick();

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Receive-side counterpart of the team's 16-step PWM generator: samples an asynchronous PWM line, measures high time and period in `clk` cycles, and recovers the 4-bit duty code the generator was driven with. Detects constant-level lines (duty 15 drives a constantly high line) and malformed periods. Sits beside the ALU/PWM top, fed from an input pin, results routed to the output mux or to a host register.

## Interface
Parameters:
- `CNT_W`, 8: width of the high-time, period and timeout counters; counters saturate at all-ones.
- `PERIOD`, 16: expected period in cycles; any other period is an error.
- `TIMEOUT`, 40: cycles without any edge before the line is declared stuck; must be greater than `PERIOD` and less than 2^`CNT_W`.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `pwm_in`  in  1  asynchronous PWM line.
- `high_cnt`  out  `CNT_W`  high cycles in the last complete period; reset 0.
- `period_cnt`  out  `CNT_W`  length of the last complete period; reset 0.
- `duty_code`  out  4  recovered duty code; reset 0.
- `valid`  out  1  one-cycle pulse when the outputs update; reset 0.
- `locked`  out  1  last measurement was a good period; reset 0.
- `period_err`  out  1  last complete period ≠ `PERIOD`; reset 0.
- `stuck_hi` / `stuck_lo`  out  1 each  line held high/low for `TIMEOUT` cycles; reset 0.

## Operation
- Synchronizer: `s1 <= pwm_in`, `s2 <= s1`, `s3 <= s2`; all reset to 0. `rise = s2 & ~s3`, `fall = ~s2 & s3`.
- FSM states: IDLE, MEASURE, STUCK.
  - IDLE: wait for `rise`. On `rise`: `pcnt <= 1`, `hcnt <= 1`, go to MEASURE. Outputs unchanged.
  - MEASURE: each non-rise cycle: `pcnt++`, `hcnt += s2`, both saturating. On `rise`: latch `period_cnt <= pcnt`, `high_cnt <= hcnt`, pulse `valid`, clear `stuck_*`, then restart the counters at 1.
    - Good period (`pcnt == PERIOD` and 1 ≤ `hcnt` ≤ `PERIOD`−1): `duty_code <= hcnt − 1`, `locked <= 1`, `period_err <= 0`.
    - Any other period: `duty_code` held, `locked <= 0`, `period_err <= 1`.
  - Edge-free counter `run`: cleared on `rise`/`fall`, otherwise incremented (saturating). In IDLE or MEASURE, when `run` reaches `TIMEOUT − 1`, go to STUCK next cycle. `locked` is cleared on that transition.
    - If `s2` = 1: set `stuck_hi`, `duty_code <= 15`, pulse `valid` once, `high_cnt`/`period_cnt` held.
    - If `s2` = 0: set `stuck_lo`, `duty_code` held, no `valid`.
  - STUCK: on `rise`, take the IDLE `rise` action and go to MEASURE; `stuck_*` stays set until the next latch. A `fall` clears `run` only.
- `rst` in any state: every register returns to its reset value the next cycle, including `s1`..`s3`. Any measurement in progress is discarded.

## Timing
- A rise on `pwm_in` captured at edge N appears as `rise` after edge N+1. The outputs and the `valid` pulse are visible after edge N+2.
- Generator with duty `d` < 15: `high_cnt` = `d`+1, `period_cnt` = 16, `valid` every 16 cycles. The first `valid` comes one full period after the first detected rise.
- A duty change shows up at the first period that is fully measured after the change.
- Constant line: the stuck flag asserts `TIMEOUT` + 1 cycles after the last `s2` edge.
- `valid` is never high for two consecutive cycles.

## Structure
- Package `pwm_cap_pkg`: FSM state enum (IDLE/MEASURE/STUCK) and default constants for `PERIOD`, `TIMEOUT` and `CNT_W`.
- Sub-module `sync_edge`: 3-flop synchronizer plus `rise`/`fall` outputs, with the same `clk`/`rst`.
- The FSM, counters and output registers live in `pwm_capture`.

## Test plan
- Reset, then generator duty 5 → first `valid` one period after the first rise; `high_cnt`=6, `period_cnt`=16, `duty_code`=5, `locked`=1, then a `valid` every 16 cycles.
- Switch duty 3 → 10 mid-stream → one partial period, then `duty_code` 3 changes to 10 with `high_cnt`=11 on the next full period; never an intermediate code with `locked`=1.
- Duty 15 (line constantly high) → `stuck_hi`=1, `duty_code`=15, exactly one `valid`, `locked`=0.
- `pwm_in` held low after lock → `stuck_lo`=1 at `TIMEOUT`+1 cycles after the fall, `duty_code` held, no `valid`.
- Square wave with period 12, high 4 → `period_err`=1, `locked`=0, `duty_code` unchanged, `period_cnt`=12.
- Assert `rst` for 1 cycle mid-period → all outputs 0 the next cycle. Measurement restarts, and the first `valid` comes one full period after the next detected rise.
